// File: rtl/wordle_pkg.sv
// Shared definitions for the wordle guess engine: letter/colour encodings,
// board geometry defaults, FSM state types and small word-access helpers.
package wordle_pkg;

    localparam int unsigned LW       = 5;
    localparam int unsigned ROWS_DEF = 6;
    localparam int unsigned COLS_DEF = 5;

    localparam logic [LW-1:0] LETTER_A = 5'd1;

    localparam logic [1:0] COL_PEND = 2'b00;
    localparam logic [1:0] COL_GRAY = 2'b01;
    localparam logic [1:0] COL_YEL  = 2'b10;
    localparam logic [1:0] COL_GRN  = 2'b11;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_ENTRY,
        S_SCORE_G,
        S_SCORE_Y,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_G,
        SC_Y
    } sc_phase_t;

    function automatic logic [LW-1:0] letter_at(input logic [LW*COLS_DEF-1:0] w,
                                                input logic [2:0] k);
        logic [LW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < COLS_DEF; i++)
            if (k == i[2:0]) r = w[i*LW +: LW];
        return r;
    endfunction

    function automatic logic [1:0] colour_at(input logic [2*COLS_DEF-1:0] res,
                                             input logic [2:0] k);
        logic [1:0] r;
        r = '0;
        for (int unsigned i = 0; i < COLS_DEF; i++)
            if (k == i[2:0]) r = res[i*2 +: 2];
        return r;
    endfunction

endpackage

// File: rtl/wordle_scorer.sv
// Scores a guess against a latched target: 5 green-pass cycles followed by a
// fixed 25-cycle yellow scan. done is high during the final scan cycle.
module wordle_scorer
    import wordle_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [LW*COLS_DEF-1:0] guess,
    input  logic [LW*COLS_DEF-1:0] target,
    output logic                   done,
    output logic [2*COLS_DEF-1:0]  result
);

    sc_phase_t         phase;
    logic [2:0]        i;
    logic [2:0]        j;
    logic [LW*COLS_DEF-1:0] tgt;
    logic [COLS_DEF-1:0]    used;
    logic [LW-1:0]     gl;
    logic [LW-1:0]     tl;

    always_comb begin
        gl = letter_at(guess, i);
        tl = letter_at(tgt, (phase == SC_G) ? i : j);
    end

    assign done = (phase == SC_Y) && (i == 3'd4) && (j == 3'd4);

    always_ff @(posedge clk) begin
        if (clr) begin
            phase  <= SC_IDLE;
            i      <= '0;
            j      <= '0;
            tgt    <= '0;
            used   <= '0;
            result <= '0;
        end else begin
            case (phase)
                SC_IDLE: begin
                    if (start) begin
                        phase <= SC_G;
                        i     <= '0;
                        j     <= '0;
                        tgt   <= target;
                        used  <= '0;
                    end
                end
                SC_G: begin
                    for (int unsigned k = 0; k < COLS_DEF; k++) begin
                        if (i == k[2:0]) begin
                            result[k*2 +: 2] <= (gl == tl) ? COL_GRN : COL_GRAY;
                            if (gl == tl) used[k] <= 1'b1;
                        end
                    end
                    if (i == 3'd4) begin
                        phase <= SC_Y;
                        i     <= '0;
                    end else begin
                        i <= i + 3'd1;
                    end
                end
                SC_Y: begin
                    // Only a still-gray cell can claim a match, so each guess letter takes at most one.
                    if (colour_at(result, i) == COL_GRAY && gl == tl && !used[j]) begin
                        for (int unsigned k = 0; k < COLS_DEF; k++)
                            if (i == k[2:0]) result[k*2 +: 2] <= COL_YEL;
                        used[j] <= 1'b1;
                    end
                    if (j == 3'd4) begin
                        j <= '0;
                        if (i == 3'd4) begin
                            phase <= SC_IDLE;
                            i     <= '0;
                        end else begin
                            i <= i + 3'd1;
                        end
                    end else begin
                        j <= j + 3'd1;
                    end
                end
                default: phase <= SC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wordle_guess_engine.sv
// Wordle game logic: builds guesses from key pulses, scores them and streams
// per-cell {colour, letter} writes to the board store; tracks win/loss.
module wordle_guess_engine
    import wordle_pkg::*;
#(
    parameter int unsigned ROWS = ROWS_DEF,
    parameter int unsigned COLS = COLS_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  letter_in,
    input  logic        letter_valid,
    input  logic        del_pulse,
    input  logic        enter_pulse,
    input  logic [24:0] target,
    output logic [6:0]  display,
    output logic [2:0]  row,
    output logic [2:0]  col,
    output logic        wr_en,
    output logic        busy,
    output logic        game_won,
    output logic        game_lost
);

    localparam logic [2:0] NCOL     = 3'(COLS);
    localparam logic [2:0] LAST_COL = 3'(COLS - 1);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [2:0]  cur_row;
    logic [2:0]  cur_col;
    logic [24:0] guess;
    logic [9:0]  result;
    logic        sc_done;
    logic        do_enter;
    logic        do_del;
    logic        do_letter;
    logic        all_green;
    logic [2:0]  wcol;
    logic [6:0]  display_d;
    logic [2:0]  row_d;
    logic [2:0]  col_d;
    logic        wr_en_d;
    logic        busy_d;

    wordle_scorer u_scorer (
        .clk    (clk),
        .clr    (clr),
        .start  (do_enter),
        .guess  (guess),
        .target (target),
        .done   (sc_done),
        .result (result)
    );

    always_comb begin
        do_enter  = (state == S_ENTRY) && enter_pulse && (cur_col == NCOL);
        do_del    = (state == S_ENTRY) && !enter_pulse && del_pulse && (cur_col != 3'd0);
        do_letter = (state == S_ENTRY) && !enter_pulse && !del_pulse && letter_valid &&
                    (letter_in >= LETTER_A) && (cur_col < NCOL);
        all_green = (result == '1);
    end

    always_ff @(posedge clk) begin
        if (clr) state <= S_CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR:   if (cnt == 5'd30) state_nx = S_ENTRY;
            S_ENTRY:   if (do_enter) state_nx = S_SCORE_G;
            S_SCORE_G: if (cnt == 5'd4) state_nx = S_SCORE_Y;
            S_SCORE_Y: if (sc_done) state_nx = S_WRITE;
            S_WRITE:   if (cnt == 5'd4)
                           state_nx = (all_green || cur_row == LAST_ROW) ? S_DONE : S_ENTRY;
            default:   state_nx = state;
        endcase
    end

    // Output registers are loaded at the edge that enters the cycle they describe,
    // so the scored writes line up with the WRITE state itself.
    always_comb begin
        wr_en_d   = 1'b0;
        row_d     = '0;
        col_d     = '0;
        display_d = '0;
        wcol      = (state == S_WRITE) ? cnt[2:0] + 3'd1 : 3'd0;
        case (state)
            S_CLEAR: begin
                if (cnt < 5'd30) begin
                    wr_en_d = 1'b1;
                    row_d   = cur_row;
                    col_d   = cur_col;
                end
            end
            S_ENTRY: begin
                if (do_del) begin
                    wr_en_d = 1'b1;
                    row_d   = cur_row;
                    col_d   = cur_col - 3'd1;
                end else if (do_letter) begin
                    wr_en_d   = 1'b1;
                    row_d     = cur_row;
                    col_d     = cur_col;
                    display_d = {COL_PEND, letter_in};
                end
            end
            default: ;
        endcase
        if (state_nx == S_WRITE) begin
            wr_en_d   = 1'b1;
            row_d     = cur_row;
            col_d     = wcol;
            display_d = {colour_at(result, wcol), letter_at(guess, wcol)};
        end
        busy_d = (state_nx == S_CLEAR) || (state_nx == S_SCORE_G) ||
                 (state_nx == S_SCORE_Y) || (state_nx == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            display <= '0;
            row     <= '0;
            col     <= '0;
            wr_en   <= 1'b0;
            busy    <= 1'b1;
        end else begin
            display <= display_d;
            row     <= row_d;
            col     <= col_d;
            wr_en   <= wr_en_d;
            busy    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt       <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            guess     <= '0;
            game_won  <= 1'b0;
            game_lost <= 1'b0;
        end else begin
            cnt <= (state_nx != state) ? 5'd0 : cnt + 5'd1;
            case (state)
                S_CLEAR: begin
                    if (cnt < 5'd30) begin
                        if (cur_col == LAST_COL) begin
                            cur_col <= '0;
                            cur_row <= (cur_row == LAST_ROW) ? 3'd0 : cur_row + 3'd1;
                        end else begin
                            cur_col <= cur_col + 3'd1;
                        end
                    end
                end
                S_ENTRY: begin
                    if (do_del) begin
                        cur_col <= cur_col - 3'd1;
                    end else if (do_letter) begin
                        for (int unsigned k = 0; k < COLS_DEF; k++)
                            if (cur_col == k[2:0]) guess[k*LW +: LW] <= letter_in;
                        cur_col <= cur_col + 3'd1;
                    end
                end
                S_WRITE: begin
                    if (cnt == 5'd4) begin
                        if (all_green) begin
                            game_won <= 1'b1;
                        end else if (cur_row == LAST_ROW) begin
                            game_lost <= 1'b1;
                        end else begin
                            cur_row <= cur_row + 3'd1;
                            cur_col <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wordle_guess_engine.sv
// Bench for wordle_guess_engine: a game-rule model predicts every write and
// flag per cycle; a compare process checks the DUT against it each cycle.
module tb_wordle_guess_engine;

    localparam int INF = 1 << 30;
    localparam logic [4:0] L_A = 5'd1,  L_B = 5'd2,  L_C = 5'd3,  L_D = 5'd4,  L_E = 5'd5;
    localparam logic [4:0] L_N = 5'd14, L_O = 5'd15, L_R = 5'd18, L_X = 5'd24;
    localparam logic [4:0] L_Y = 5'd25, L_Z = 5'd26;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [4:0]  letter_in = '0;
    logic        letter_valid = 1'b0;
    logic        del_pulse = 1'b0;
    logic        enter_pulse = 1'b0;
    logic [24:0] target = '0;
    logic [6:0]  display;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        wr_en;
    logic        busy;
    logic        game_won;
    logic        game_lost;

    wordle_guess_engine #(.ROWS(6), .COLS(5)) dut (
        .clk          (clk),
        .clr          (clr),
        .letter_in    (letter_in),
        .letter_valid (letter_valid),
        .del_pulse    (del_pulse),
        .enter_pulse  (enter_pulse),
        .target       (target),
        .display      (display),
        .row          (row),
        .col          (col),
        .wr_en        (wr_en),
        .busy         (busy),
        .game_won     (game_won),
        .game_lost    (game_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int         lbl;
        logic [2:0] r;
        logic [2:0] c;
        logic [6:0] d;
    } wr_t;
    wr_t q[$];

    int          m_ready = INF;
    int          m_won_from = INF;
    int          m_lost_from = INF;
    bit          m_done = 1'b0;
    int          m_row = 0;
    int          m_col = 0;
    logic [24:0] m_guess = '0;

    logic [6:0]  seen_disp [6][5];
    logic [2:0]  last_row = '0;
    logic [2:0]  last_col = '0;
    logic [6:0]  last_disp = '0;

    function automatic logic [24:0] w5(input logic [4:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    // Classic two-pass scoring: greens first, then left-to-right yellows from
    // the per-letter count of unmatched target letters.
    function automatic logic [9:0] score(input logic [24:0] g, input logic [24:0] t);
        int          remaining [32];
        logic [9:0]  r;
        logic [4:0]  gl;
        logic [4:0]  tl;
        r = '0;
        for (int k = 0; k < 32; k++) remaining[k] = 0;
        for (int k = 0; k < 5; k++) begin
            gl = g[5*k +: 5];
            tl = t[5*k +: 5];
            if (gl == tl) r[2*k +: 2] = 2'b11;
            else remaining[tl] = remaining[tl] + 1;
        end
        for (int k = 0; k < 5; k++) begin
            gl = g[5*k +: 5];
            if (r[2*k +: 2] != 2'b11) begin
                if (remaining[gl] > 0) begin
                    r[2*k +: 2] = 2'b10;
                    remaining[gl] = remaining[gl] - 1;
                end else begin
                    r[2*k +: 2] = 2'b01;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin : compare
        logic exp_w;
        if (cyc >= 1) begin
            exp_w = (q.size() > 0) && (q[0].lbl == cyc);
            total++;
            if (wr_en !== exp_w) begin
                bad++;
                $display("FAIL wr_en cyc=%0d: got %b, expected %b", cyc, wr_en, exp_w);
            end else if (exp_w && (row !== q[0].r || col !== q[0].c || display !== q[0].d)) begin
                bad++;
                $display("FAIL write cyc=%0d: got r%0d c%0d d%b, expected r%0d c%0d d%b",
                         cyc, row, col, display, q[0].r, q[0].c, q[0].d);
            end
            if (exp_w) void'(q.pop_front());
            total++;
            if (busy !== (cyc < m_ready) || game_won !== (cyc >= m_won_from) ||
                game_lost !== (cyc >= m_lost_from)) begin
                bad++;
                $display("FAIL flags cyc=%0d: got busy=%b won=%b lost=%b, expected %b %b %b",
                         cyc, busy, game_won, game_lost, cyc < m_ready,
                         cyc >= m_won_from, cyc >= m_lost_from);
            end
            if (wr_en === 1'b1 && row < 3'd6 && col < 3'd5) begin
                seen_disp[row][col] = display;
                last_row  = row;
                last_col  = col;
                last_disp = display;
            end
        end
    end

    task automatic push(input int lbl, input int r, input int c, input logic [6:0] d);
        wr_t w;
        w.lbl = lbl;
        w.r   = 3'(r);
        w.c   = 3'(c);
        w.d   = d;
        q.push_back(w);
    endtask

    task automatic do_reset();
        int r;
        clr = 1'b1;
        @(posedge clk); #2;
        q.delete();
        m_ready = INF; m_won_from = INF; m_lost_from = INF; m_done = 1'b0;
        @(posedge clk); #2;
        clr = 1'b0;
        r = cyc;
        m_row = 0; m_col = 0; m_guess = '0;
        m_ready = r + 31;
        for (int n = 0; n < 30; n++) push(r + 1 + n, n / 5, n % 5, 7'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cyc < m_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (cyc < m_ready) begin
            total++; bad++;
            $display("FAIL wait_ready timeout at cyc=%0d", cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse(input logic l, input logic d, input logic e, input logic [4:0] ltr);
        int          s;
        logic [9:0]  res;
        letter_in = ltr; letter_valid = l; del_pulse = d; enter_pulse = e;
        @(posedge clk); #2;
        letter_in = '0; letter_valid = 1'b0; del_pulse = 1'b0; enter_pulse = 1'b0;
        s = cyc;
        if (!m_done && (s - 1 >= m_ready)) begin
            if (e) begin
                if (m_col == 5) begin
                    res = score(m_guess, target);
                    for (int c = 0; c < 5; c++)
                        push(s + 30 + c, m_row, c, {res[2*c +: 2], m_guess[5*c +: 5]});
                    m_ready = s + 35;
                    if (res == 10'h3FF) begin
                        m_won_from = s + 35; m_done = 1'b1;
                    end else if (m_row == 5) begin
                        m_lost_from = s + 35; m_done = 1'b1;
                    end else begin
                        m_row++; m_col = 0;
                    end
                end
            end else if (d) begin
                if (m_col > 0) begin
                    m_col--;
                    push(s, m_row, m_col, 7'd0);
                end
            end else if (l && ltr != 5'd0 && m_col < 5) begin
                push(s, m_row, m_col, {2'b00, ltr});
                m_guess[5*m_col +: 5] = ltr;
                m_col++;
            end
        end
    endtask

    task automatic type_word(input logic [24:0] w);
        for (int k = 0; k < 5; k++) pulse(1'b1, 1'b0, 1'b0, w[5*k +: 5]);
    endtask

    initial begin
        // Pin the model's scoring rules with hand-computed results.
        check("score_crane_win", 32'(score(w5(L_C, L_R, L_A, L_N, L_E), w5(L_C, L_R, L_A, L_N, L_E))),
              32'h3FF);
        check("score_bobby_abbey", 32'(score(w5(L_B, L_O, L_B, L_B, L_Y), w5(L_A, L_B, L_B, L_E, L_Y))),
              32'(10'b11_01_11_01_10));
        check("score_crane_abbey", 32'(score(w5(L_C, L_R, L_A, L_N, L_E), w5(L_A, L_B, L_B, L_E, L_Y))),
              32'(10'b10_01_10_01_01));

        // Game 1: entry edge cases, duplicates, then a loss.
        do_reset();
        wait_ready();
        check("busy_after_clear", 32'(busy), 32'd0);
        target = w5(L_A, L_B, L_B, L_E, L_Y);
        pulse(1'b0, 1'b1, 1'b0, 5'd0);
        pulse(1'b1, 1'b0, 1'b0, L_C);
        pulse(1'b1, 1'b0, 1'b0, L_R);
        pulse(1'b1, 1'b0, 1'b0, L_A);
        pulse(1'b0, 1'b1, 1'b0, 5'd0);
        wait_cycles(1);
        check("del_col2_col", 32'(last_col), 32'd2);
        check("del_col2_disp", 32'(last_disp), 32'd0);
        pulse(1'b1, 1'b1, 1'b0, L_X);
        pulse(1'b1, 1'b0, 1'b0, L_R);
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        pulse(1'b1, 1'b0, 1'b0, L_A);
        pulse(1'b1, 1'b0, 1'b0, L_N);
        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        pulse(1'b1, 1'b0, 1'b0, L_E);
        pulse(1'b1, 1'b0, 1'b0, L_Z);
        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        wait_ready();
        type_word(w5(L_B, L_O, L_B, L_B, L_Y));
        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        wait_ready();
        check("bobby_col0", 32'(seen_disp[1][0]), 32'(7'b1000010));
        check("bobby_col2", 32'(seen_disp[1][2]), 32'(7'b1100010));
        check("bobby_col3", 32'(seen_disp[1][3]), 32'(7'b0100010));
        for (int g = 0; g < 4; g++) begin
            type_word(w5(L_C, L_R, L_A, L_N, L_E));
            pulse(1'b0, 1'b0, 1'b1, 5'd0);
            wait_ready();
        end
        check("game_lost", 32'(game_lost), 32'd1);
        check("game_won_on_loss", 32'(game_won), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, L_A);
        pulse(1'b0, 1'b1, 1'b0, 5'd0);
        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        wait_cycles(40);

        // Game 2: a win; target changes after enter must not matter.
        do_reset();
        wait_ready();
        check("lost_cleared", 32'(game_lost), 32'd0);
        target = w5(L_C, L_R, L_A, L_N, L_E);
        type_word(w5(L_C, L_R, L_A, L_N, L_E));
        wait_cycles(1);
        check("pending_c", 32'(seen_disp[0][0]), 32'(7'b0000011));
        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        target = w5(L_A, L_B, L_B, L_E, L_Y);
        wait_ready();
        check("game_won", 32'(game_won), 32'd1);
        check("green_e", 32'(seen_disp[0][4]), 32'(7'b1100101));
        pulse(1'b1, 1'b0, 1'b0, L_A);
        wait_cycles(5);

        // Game 3: clr during the yellow scan aborts scoring and restarts at row 0.
        do_reset();
        wait_ready();
        type_word(w5(L_A, L_B, L_C, L_D, L_E));
        pulse(1'b0, 1'b0, 1'b1, 5'd0);
        wait_cycles(15);
        do_reset();
        wait_ready();
        pulse(1'b1, 1'b0, 1'b0, L_Y);
        wait_cycles(2);
        check("after_abort_row", 32'(last_row), 32'd0);
        check("after_abort_disp", 32'(last_disp), 32'(7'b0011001));
        wait_cycles(5);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wordle_guess_engine.md
Name: wordle_guess_engine

Overview:
Game-logic stage directly upstream of the VGA controller. Accepts letter/delete/enter pulses, builds each 5-letter guess, scores it against the target word with correct duplicate-letter handling, and streams per-cell {colour, letter} writes (display/row/col/wr_en) into the VGA board store. It also tracks win/loss and clears the board after reset.

Parameters:
ROWS, 6, number of guess rows (row index 0..ROWS-1)
COLS, 5, letters per guess (fixed at 5; target width 5*5 bits)

Ports:
clk  input  1  system clock
clr  input  1  synchronous active-high reset
letter_in  input  5  letter code, A=1..Z=26 (0 is illegal and ignored)
letter_valid  input  1  one-cycle pulse: append letter_in
del_pulse  input  1  one-cycle pulse: remove last letter
enter_pulse  input  1  one-cycle pulse: submit guess
target  input  25  target word; letter k at [5k+4:5k], k=0 leftmost
display  output  7  cell content: [6:5] colour, [4:0] letter (0 = blank)
row  output  3  cell row for this write
col  output  3  cell column for this write
wr_en  output  1  display/row/col valid this cycle
busy  output  1  high in CLEAR/SCORE_G/SCORE_Y/WRITE
game_won  output  1  sticky until clr
game_lost  output  1  sticky until clr

Behaviour:
- Single clock domain: clk. clr is synchronous and active-high. All outputs are registered.
- Colour codes: 00 pending (typed, unscored); 01 gray; 10 yellow; 11 green.
- Reset values: display=0, row=0, col=0, wr_en=0, busy=1, game_won=0, game_lost=0. Internal cur_row=0, cur_col=0, state=CLEAR.
- States: CLEAR, ENTRY, SCORE_G, SCORE_Y, WRITE, DONE.
- CLEAR: in cycle n after clr deasserts (n=1..30), wr_en=1 and display=0 for cell n-1 (row=(n-1)/5, col=(n-1)%5). The state then moves to ENTRY and busy drops.
- ENTRY, input priority when several pulses coincide: enter > del > letter. Lower-priority pulses in the same cycle are dropped.
  - letter with cur_col<5 and letter_in!=0: next cycle drives wr_en=1, row=cur_row, col=cur_col, display={00,letter_in}. The letter is stored and cur_col increments. If cur_col==5 the letter is ignored and no write occurs.
  - del with cur_col>0: next cycle writes display=0 at col=cur_col-1 and cur_col decrements. If cur_col==0 the delete is ignored.
  - enter with cur_col==5: target is latched and the state moves to SCORE_G. If cur_col<5 the enter is ignored.
- SCORE_G (5 cycles, i=0..4): if guess[i]==tgt[i], result[i]=green and used[i]=1. Otherwise result[i]=gray.
- SCORE_Y (25 cycles, i outer, j inner, 0..4): if result[i] is not green, guess[i]==tgt[j], and used[j]=0, then result[i]=yellow and used[j]=1. Each i takes at most one match. Scan length is fixed, with no early exit.
- WRITE (5 cycles): wr_en=1, row=cur_row, col=0..4, display={result[col],guess[col]}.
- After WRITE:
  - all five green: game_won=1, go to DONE.
  - otherwise, cur_row==ROWS-1: game_lost=1, go to DONE.
  - otherwise: cur_row increments, cur_col=0, go to ENTRY.
- Timing: enter accepted at cycle t. SCORE_G runs t+1..t+5, SCORE_Y t+6..t+30, writes occur t+31..t+35, ENTRY or DONE from t+36.
- All pulses are ignored while busy and in DONE. DONE holds until clr.
- wr_en is 0 in every cycle not listed above.
- clr asserted in any state aborts the operation immediately and restarts the CLEAR sweep. Partial guesses and flags are discarded.

Decomposition:
- Shared package wordle_pkg holds:
  - colour constants COL_PEND, COL_GRAY, COL_YEL, COL_GRN
  - letter width (5) and the A=1 encoding
  - ROWS/COLS defaults
  - the state enum
- One natural sub-module: wordle_scorer. It takes start, guess[24:0], target[24:0] and returns done plus result[9:0], implementing SCORE_G/SCORE_Y with the same cycle counts.

Test Plan:
- Reset sweep: clr high 2 cycles then low -> 30 consecutive wr_en pulses covering (0,0)..(5,4) with display=0, then busy=0.
- Type C,R,A,N,E (3,18,1,14,5) -> writes display 7'b0000011.. at row0 col0..4. Target "CRANE", enter -> 35 cycles later five writes with display[6:5]=11, then game_won=1 and DONE.
- Duplicates: target "ABBEY", guess "BOBBY" -> colours col0..4 = yellow, gray, green, gray, green. col0 is display 7'b1000010 and col3 is 7'b0100010.
- Edge inputs:
  - 6th letter -> no write.
  - del at col0 -> no write.
  - enter at col 4 -> ignored.
  - letter+del same cycle -> only delete.
  - del after 3 letters -> write display=0 at col2.
- Six wrong guesses -> game_lost=1 after row5 WRITE. Further pulses produce no writes until clr.
- clr asserted during SCORE_Y -> no scored writes emitted, CLEAR sweep restarts, cur_row=0.
